// File: rtl/writeback_merge_if.sv
// ---------------------------------------------------------------------------
// writeback_merge_if
//   Bundles the two execution-pipe result streams and the register-file
//   write port / issue feedback of writeback_merge.
//
//   x_wb_*   : X-pipe (single-cycle ALU) result request
//   y_wb_*   : Y-pipe (4-stage multiplier) result request
//   wb_rf_*  : register-file write port
//   wb_is_stall, wb_overflow, wb_collisions : status back to issue / debug
//
//   master : the pipes / issue side (drives results, observes port + status)
//   slave  : writeback_merge itself
// ---------------------------------------------------------------------------
interface writeback_merge_if;
    logic [4:0]  x_wb_regdest;
    logic        x_wb_writereg;
    logic [31:0] x_wb_wbvalue;
    logic [4:0]  y_wb_regdest;
    logic        y_wb_writereg;
    logic [31:0] y_wb_wbvalue;
    logic [4:0]  wb_rf_regdest;
    logic        wb_rf_writereg;
    logic [31:0] wb_rf_wbvalue;
    logic        wb_is_stall;
    logic        wb_overflow;
    logic [15:0] wb_collisions;

    modport master (
        output x_wb_regdest, x_wb_writereg, x_wb_wbvalue,
        output y_wb_regdest, y_wb_writereg, y_wb_wbvalue,
        input  wb_rf_regdest, wb_rf_writereg, wb_rf_wbvalue,
        input  wb_is_stall, wb_overflow, wb_collisions
    );

    modport slave (
        input  x_wb_regdest, x_wb_writereg, x_wb_wbvalue,
        input  y_wb_regdest, y_wb_writereg, y_wb_wbvalue,
        output wb_rf_regdest, wb_rf_writereg, wb_rf_wbvalue,
        output wb_is_stall, wb_overflow, wb_collisions
    );
endinterface

// File: rtl/writeback_merge.sv
// ---------------------------------------------------------------------------
// writeback_merge
//   Merges the X-pipe and Y-pipe result streams onto the single register-file
//   write port. Y always wins; an X result that collides with Y (or that
//   arrives while older X results are still queued) goes into a small
//   in-order FIFO that drains whenever Y leaves the port free.
//
//   Ports:
//     clock  : rising-edge clock
//     reset  : asynchronous active-low reset
//     wb     : writeback_merge_if.slave
//              x_wb_* / y_wb_*  result requests (regdest==0 is ignored)
//              wb_rf_*          registered register-file write, 1-cycle latency
//              wb_is_stall      registered, asks issue to hold the X pipe
//              wb_overflow      sticky, an X result was dropped on a full FIFO
//              wb_collisions    saturating count of X/Y same-cycle requests
// ---------------------------------------------------------------------------
module writeback_merge #(
    parameter int DEPTH = 4,
    parameter int PTRW  = 2
) (
    input  logic            clock,
    input  logic            reset,
    writeback_merge_if.slave wb
);

    localparam logic [PTRW:0] CNT_FULL  = (PTRW+1)'(DEPTH);
    localparam logic [PTRW:0] CNT_STALL = (PTRW+1)'(DEPTH - 1);

    typedef struct packed {
        logic [4:0]  regdest;
        logic [31:0] wbvalue;
    } wb_entry_t;

    // FIFO state
    wb_entry_t       mem [DEPTH];
    logic [PTRW-1:0] wr_ptr, rd_ptr;
    logic [PTRW:0]   count, count_next;

    // Filtered requests: a write to r0 is architecturally a no-op.
    logic x_req, y_req;
    logic fifo_empty, fifo_full;
    logic pop, push, push_ok, drop;

    assign x_req      = wb.x_wb_writereg && (wb.x_wb_regdest != 5'd0);
    assign y_req      = wb.y_wb_writereg && (wb.y_wb_regdest != 5'd0);
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_FULL);

    // Queued X results drain only when Y leaves the port free. Any valid X
    // that cannot bypass (Y busy, or older X still queued) must enqueue so
    // X results stay in program order.
    assign pop     = !y_req && !fifo_empty;
    assign push    = x_req && (y_req || !fifo_empty);
    // A pop in the same cycle frees a slot, so a full FIFO only drops when
    // nothing leaves it.
    assign drop    = push && fifo_full && !pop;
    assign push_ok = push && !drop;

    always_comb begin
        // NOTE: every signal driven in always_comb gets a default first so no
        // path leaves it unassigned and a latch is never inferred.
        count_next = count;
        case ({push_ok, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // NOTE: the FIFO storage has no reset; only the pointers and count define
    // which entries are live, so stale contents are never observed.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= '{regdest: wb.x_wb_regdest, wbvalue: wb.x_wb_wbvalue};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    // Register-file port and status outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb.wb_rf_regdest  <= '0;
            wb.wb_rf_writereg <= 1'b0;
            wb.wb_rf_wbvalue  <= '0;
            wb.wb_is_stall    <= 1'b0;
            wb.wb_overflow    <= 1'b0;
            wb.wb_collisions  <= '0;
        end else begin
            if (y_req) begin
                wb.wb_rf_writereg <= 1'b1;
                wb.wb_rf_regdest  <= wb.y_wb_regdest;
                wb.wb_rf_wbvalue  <= wb.y_wb_wbvalue;
            end else if (pop) begin
                wb.wb_rf_writereg <= 1'b1;
                wb.wb_rf_regdest  <= mem[rd_ptr].regdest;
                wb.wb_rf_wbvalue  <= mem[rd_ptr].wbvalue;
            end else if (x_req) begin
                wb.wb_rf_writereg <= 1'b1;
                wb.wb_rf_regdest  <= wb.x_wb_regdest;
                wb.wb_rf_wbvalue  <= wb.x_wb_wbvalue;
            end else begin
                // Address and data hold; only the enable drops.
                wb.wb_rf_writereg <= 1'b0;
            end

            // Stalling at DEPTH-1 leaves one slot for the X result that is
            // already in flight when issue first sees the stall.
            wb.wb_is_stall <= (count_next >= CNT_STALL);

            if (drop) wb.wb_overflow <= 1'b1;

            if (x_req && y_req && (wb.wb_collisions != 16'hFFFF)) begin
                wb.wb_collisions <= wb.wb_collisions + 16'd1;
            end
        end
    end

endmodule
